// File: rtl/spi_memory_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_memory_master_pkg
//  Purpose  : Shared widths, frame constants and FSM encodings for the
//             SPI serial-memory master.
//  Revision : 1.0  initial release
// ============================================================================
package spi_memory_master_pkg;

    localparam int c_MEM_ADDR_WIDTH     = 15;
    localparam int c_MEM_DATA_WIDTH     = 8;
    localparam int c_BYTE_WIDTH         = 8;
    localparam int c_SPI_WRITE_FLAG_BIT = 7;

    // Top-level transaction states
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SELECT   = 3'd1;
    localparam logic [2:0] c_ST_ADDR_LO  = 3'd2;
    localparam logic [2:0] c_ST_ADDR_HI  = 3'd3;
    localparam logic [2:0] c_ST_DATA     = 3'd4;
    localparam logic [2:0] c_ST_STALL    = 3'd5;
    localparam logic [2:0] c_ST_DESELECT = 3'd6;
    localparam logic [2:0] c_ST_HOLD     = 3'd7;

    // Second frame byte: upper address bits with the write flag on top.
    function automatic logic [c_BYTE_WIDTH-1:0] cmd_byte(
        input logic                          i_write,
        input logic [c_MEM_ADDR_WIDTH-9:0]   i_addr_hi
    );
        logic [c_BYTE_WIDTH-1:0] r_b;
        r_b = c_BYTE_WIDTH'(i_addr_hi);
        r_b[c_SPI_WRITE_FLAG_BIT] = i_write;
        return r_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_byte_shifter
//  Purpose  : Half-period divider plus one-byte LSB-first SPI shifter.
//             A byte is 8 x (low, high) half-periods followed by one extra
//             low half-period, after which completion is reported.
//  Revision : 1.0  initial release
// ============================================================================
module spi_byte_shifter
    import spi_memory_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [c_BYTE_WIDTH-1:0] i_byte,
    input  logic                    i_miso,
    output logic                    o_tick,
    output logic                    o_tail_start,
    output logic                    o_byte_done,
    output logic                    o_sck,
    output logic                    o_mosi,
    output logic [c_BYTE_WIDTH-1:0] o_rx_byte
);

    localparam logic [7:0] c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] c_HP_TAIL   = 5'd16;
    localparam logic [4:0] c_HP_LAST_H = 5'd15;

    logic [7:0]              r_div;
    logic                    r_active;
    logic [4:0]              r_hp;
    logic                    r_sck;
    logic                    r_mosi;
    logic [c_BYTE_WIDTH-2:0] r_tx_sh;
    logic [c_BYTE_WIDTH-1:0] r_rx_sh;
    logic                    w_tick;
    logic                    w_edge;

    assign w_tick       = i_en & (r_div == c_DIV_LAST);
    assign w_edge       = r_active & w_tick;
    assign o_tick       = w_tick;
    assign o_tail_start = w_edge & (r_hp == c_HP_LAST_H);
    assign o_byte_done  = w_edge & (r_hp == c_HP_TAIL);
    assign o_sck        = r_sck;
    assign o_mosi       = r_mosi;
    assign o_rx_byte    = r_rx_sh;

    // Half-period divider; a byte load realigns it so every phase is exact
    always_ff @(posedge clk) begin
        if (reset || !i_en || i_load || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    // Phase sequencing: even half-periods low, odd high, index 16 is the gap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_hp     <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_tx_sh  <= '0;
            r_rx_sh  <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_hp     <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= i_byte[0];
            r_tx_sh  <= i_byte[c_BYTE_WIDTH-1:1];
        end else if (w_edge) begin
            if (r_hp == c_HP_TAIL) begin
                r_active <= 1'b0;
            end else begin
                r_hp <= r_hp + 5'd1;
                if (!r_hp[0]) begin
                    r_sck   <= 1'b1;
                    r_rx_sh <= {i_miso, r_rx_sh[c_BYTE_WIDTH-1:1]};
                end else begin
                    r_sck <= 1'b0;
                    if (r_hp != c_HP_LAST_H) begin
                        r_mosi  <= r_tx_sh[0];
                        r_tx_sh <= {1'b0, r_tx_sh[c_BYTE_WIDTH-2:1]};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_memory_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_memory_master
//  Purpose  : SPI master for a serial memory: select, two address bytes,
//             len data bytes (write from tx stream / read to rx stream),
//             deselect and hold.
//  Revision : 1.0  initial release
// ============================================================================
module spi_memory_master
    import spi_memory_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        write,
    input  logic [c_MEM_ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic [c_MEM_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [c_MEM_DATA_WIDTH-1:0] rx_data,
    output logic                        rx_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        _select,
    output logic                        sck,
    output logic                        mosi,
    input  logic                        miso
);

    logic [2:0]                  r_state;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_sel_n;
    logic                        r_tx_ready;
    logic                        r_rx_valid;
    logic [c_MEM_DATA_WIDTH-1:0] r_rx_data;
    logic                        r_write;
    logic [c_MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]        r_remain;
    logic [c_BYTE_WIDTH-1:0]     r_hold;
    logic                        r_have;

    logic                        w_tick;
    logic                        w_tail_start;
    logic                        w_byte_done;
    logic [c_BYTE_WIDTH-1:0]     w_rx_byte;
    logic                        w_accept;
    logic                        w_avail;
    logic [c_BYTE_WIDTH-1:0]     w_next_byte;
    logic                        w_load;
    logic [c_BYTE_WIDTH-1:0]     w_load_byte;

    assign w_accept    = tx_valid & r_tx_ready;
    assign w_avail     = r_have | w_accept;
    assign w_next_byte = r_have ? r_hold : tx_data;

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign _select  = r_sel_n;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .i_en         (r_busy),
        .i_load       (w_load),
        .i_byte       (w_load_byte),
        .i_miso       (miso),
        .o_tick       (w_tick),
        .o_tail_start (w_tail_start),
        .o_byte_done  (w_byte_done),
        .o_sck        (sck),
        .o_mosi       (mosi),
        .o_rx_byte    (w_rx_byte)
    );

    // Decide when the shifter starts its next byte and what it shifts out
    always_comb begin
        w_load      = 1'b0;
        w_load_byte = '0;
        case (r_state)
            c_ST_SELECT: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_load_byte = r_addr[c_BYTE_WIDTH-1:0];
                end
            end
            c_ST_ADDR_LO: begin
                if (w_byte_done) begin
                    w_load      = 1'b1;
                    w_load_byte = cmd_byte(r_write, r_addr[c_MEM_ADDR_WIDTH-1:8]);
                end
            end
            c_ST_ADDR_HI: begin
                if (w_byte_done && r_remain != '0 && (!r_write || w_avail)) begin
                    w_load      = 1'b1;
                    w_load_byte = r_write ? w_next_byte : '0;
                end
            end
            c_ST_DATA: begin
                if (w_byte_done && r_remain != LEN_WIDTH'(1) && (!r_write || w_avail)) begin
                    w_load      = 1'b1;
                    w_load_byte = r_write ? w_next_byte : '0;
                end
            end
            c_ST_STALL: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_byte = tx_data;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM, handshakes and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sel_n    <= 1'b1;
            r_tx_ready <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_remain   <= '0;
            r_hold     <= '0;
            r_have     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx_ready <= 1'b0;
                if (r_state != c_ST_STALL) begin
                    r_hold <= tx_data;
                    r_have <= 1'b1;
                end
            end
            // A byte handed to the shifter empties the holding slot
            if (w_load) begin
                r_have <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    // done cycle is also busy=0; a start there is dropped
                    if (start && !r_done) begin
                        r_busy   <= 1'b1;
                        r_sel_n  <= 1'b0;
                        r_write  <= write;
                        r_addr   <= addr;
                        r_remain <= len;
                        r_state  <= c_ST_SELECT;
                    end
                end
                c_ST_SELECT: begin
                    if (w_tick) begin
                        r_state <= c_ST_ADDR_LO;
                    end
                end
                c_ST_ADDR_LO: begin
                    if (w_byte_done) begin
                        r_state <= c_ST_ADDR_HI;
                    end
                end
                c_ST_ADDR_HI: begin
                    if (w_tail_start && r_write && r_remain != '0) begin
                        r_tx_ready <= 1'b1;
                    end
                    if (w_byte_done) begin
                        if (r_remain == '0) begin
                            r_state <= c_ST_DESELECT;
                        end else if (w_load) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            r_state <= c_ST_STALL;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_tail_start && r_write && r_remain > LEN_WIDTH'(1)) begin
                        r_tx_ready <= 1'b1;
                    end
                    if (w_byte_done) begin
                        r_remain <= r_remain - LEN_WIDTH'(1);
                        if (!r_write) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= w_rx_byte;
                        end
                        if (r_remain == LEN_WIDTH'(1)) begin
                            r_state <= c_ST_DESELECT;
                        end else if (w_load) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            r_state <= c_ST_STALL;
                        end
                    end
                end
                c_ST_STALL: begin
                    if (w_accept) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DESELECT: begin
                    if (w_tick) begin
                        r_sel_n <= 1'b1;
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_memory_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_memory_master
//  Purpose  : Directed self-checking bench for spi_memory_master, with a
//             serial-memory slave model on miso and two extra instances at
//             CLK_DIV=2 and CLK_DIV=7 for half-period timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_memory_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CLK_DIV=4)
    logic        reset, start, write, tx_valid, tx_ready, rx_valid;
    logic        busy, done, sel_n, sck, mosi, miso;
    logic [14:0] addr;
    logic [7:0]  len, tx_data, rx_data;

    spi_memory_master #(.CLK_DIV(4), .LEN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .write(write), .addr(addr),
        .len(len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        ._select(sel_n), .sck(sck), .mosi(mosi), .miso(miso)
    );

    // Timing instances share one stimulus: read of 0x7ffe, len 0
    logic        a_reset, a_start, a_write, a_txv, a_miso;
    logic [14:0] a_addr;
    logic [7:0]  a_len, a_txd;
    logic        a_txr2, a_rxv2, a_busy2, a_done2, a_sel2, a_sck2, a_mosi2;
    logic        a_txr7, a_rxv7, a_busy7, a_done7, a_sel7, a_sck7, a_mosi7;
    logic [7:0]  a_rxd2, a_rxd7;

    spi_memory_master #(.CLK_DIV(2), .LEN_WIDTH(8)) dut_div2 (
        .clk(clk), .reset(a_reset), .start(a_start), .write(a_write), .addr(a_addr),
        .len(a_len), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr2),
        .rx_data(a_rxd2), .rx_valid(a_rxv2), .busy(a_busy2), .done(a_done2),
        ._select(a_sel2), .sck(a_sck2), .mosi(a_mosi2), .miso(a_miso)
    );

    spi_memory_master #(.CLK_DIV(7), .LEN_WIDTH(8)) dut_div7 (
        .clk(clk), .reset(a_reset), .start(a_start), .write(a_write), .addr(a_addr),
        .len(a_len), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr7),
        .rx_data(a_rxd7), .rx_valid(a_rxv7), .busy(a_busy7), .done(a_done7),
        ._select(a_sel7), .sck(a_sck7), .mosi(a_mosi7), .miso(a_miso)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    logic [7:0]  mosi_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  cur_byte;
    int          rises, dones, rx_pulses;
    logic        cur_write;
    logic [14:0] cur_addr;
    logic [7:0]  wdata[8];
    logic [7:0]  exp_b[8];
    logic [7:0]  exp_rx[8];

    // Frame decoder and slave model: data byte j of a read returns the
    // low byte of (addr + j), i.e. a memory whose contents equal their address
    initial begin : g_monitor
        logic       prev_sck;
        logic [7:0] mb;
        int         j, b;
        prev_sck = 1'b0;
        forever begin
            @(negedge clk);
            if (sck && !prev_sck && !sel_n) begin
                cur_byte = {mosi, cur_byte[7:1]};
                rises++;
                if (rises % 8 == 0) mosi_q.push_back(cur_byte);
            end
            if (done) dones++;
            if (rx_valid) begin
                rx_pulses++;
                rx_q.push_back(rx_data);
            end
            if (rises >= 16 && !cur_write) begin
                j    = (rises - 16) / 8;
                b    = (rises - 16) % 8;
                mb   = cur_addr[7:0] + 8'(j);
                miso = mb[b];
            end else begin
                miso = 1'b0;
            end
            prev_sck = sck;
        end
    end

    // Timing-instance counters
    int sel2, hi2, r2, sel7, hi7, r7;
    initial begin : g_aux_monitor
        logic p2, p7;
        p2 = 1'b0;
        p7 = 1'b0;
        forever begin
            @(negedge clk);
            if (a_sel2 === 1'b0) sel2++;
            if (a_sck2 === 1'b1) hi2++;
            if (a_sck2 === 1'b1 && !p2) r2++;
            if (a_sel7 === 1'b0) sel7++;
            if (a_sck7 === 1'b1) hi7++;
            if (a_sck7 === 1'b1 && !p7) r7++;
            p2 = (a_sck2 === 1'b1);
            p7 = (a_sck7 === 1'b1);
        end
    end

    task automatic clear_mon(input logic w, input logic [14:0] a);
        mosi_q.delete();
        rx_q.delete();
        rises     = 0;
        dones     = 0;
        rx_pulses = 0;
        cur_byte  = 8'h00;
        cur_write = w;
        cur_addr  = a;
    endtask

    // One transaction: optional stall before data byte stall_at, optional
    // extra starts while busy and a start on the done cycle
    task automatic do_txn(input logic w, input logic [14:0] a, input logic [7:0] n,
                          input int stall_at, input bit extra);
        int k;
        int errs;
        bit got;
        clear_mon(w, a);
        @(negedge clk);
        start = 1'b1; write = w; addr = a; len = n;
        @(negedge clk);
        start = 1'b0;
        if (w) begin
            for (int i = 0; i < int'(n); i++) begin
                got = 1'b0;
                for (k = 0; k < 4000; k++) begin
                    if (tx_ready) begin
                        got = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                if (!got) begin
                    chk("tx_ready timeout", 32'd0, 32'd1);
                    break;
                end
                if (i == stall_at) begin
                    errs = 0;
                    repeat (50) begin
                        @(negedge clk);
                        if (sck !== 1'b0 || sel_n !== 1'b0) errs++;
                    end
                    chk("stall sck/select low", errs, 0);
                    chk("stall tx_ready held", tx_ready, 1);
                end
                tx_valid = 1'b1;
                tx_data  = wdata[i];
                @(negedge clk);
                tx_valid = 1'b0;
            end
        end
        got = 1'b0;
        for (k = 0; k < 20000; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            start = extra && (k == 30 || k == 200);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done seen", got, 1);
        if (extra && got) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            errs = 0;
            repeat (60) begin
                @(negedge clk);
                if (busy || !sel_n) errs++;
            end
            chk("start on done ignored", errs, 0);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string tag, input int n);
        chk({tag, " byte count"}, mosi_q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s mosi byte%0d", tag, i),
                (i < mosi_q.size()) ? 32'(mosi_q[i]) : 32'hdead, 32'(exp_b[i]));
        end
    endtask

    task automatic chk_rx(input string tag, input int n);
        chk({tag, " rx_valid pulses"}, rx_pulses, n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s rx byte%0d", tag, i),
                (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hdead, 32'(exp_rx[i]));
        end
    endtask

    initial begin : g_main
        int  k;
        bit  got;
        reset = 1'b1; start = 1'b0; write = 1'b0; addr = '0; len = '0;
        tx_data = '0; tx_valid = 1'b0; miso = 1'b0;
        a_reset = 1'b1; a_start = 1'b0; a_write = 1'b0; a_addr = 15'h7ffe;
        a_len = 8'd0; a_txd = 8'd0; a_txv = 1'b0; a_miso = 1'b0;
        cur_write = 1'b1; cur_addr = '0; cur_byte = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset _select", sel_n, 1);
        chk("reset sck", sck, 0);
        chk("reset mosi", mosi, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset tx_ready", tx_ready, 0);
        chk("reset rx_data", rx_data, 0);
        reset = 1'b0;
        a_reset = 1'b0;
        @(negedge clk);

        // Write 0x5ead, 4 bytes
        wdata = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        do_txn(1'b1, 15'h5ead, 8'd4, -1, 1'b0);
        exp_b = '{8'had, 8'hde, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00};
        chk_frame("wr5ead", 6);
        chk("wr5ead sck rises", rises, 48);
        chk("wr5ead done pulses", dones, 1);
        chk("wr5ead rx_valid pulses", rx_pulses, 0);

        // Read 0x5afe, 4 bytes
        do_txn(1'b0, 15'h5afe, 8'd4, -1, 1'b0);
        exp_b  = '{8'hfe, 8'h5a, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_rx = '{8'hfe, 8'hff, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("rd5afe", 6);
        chk_rx("rd5afe", 4);
        chk("rd5afe sck rises", rises, 48);
        chk("rd5afe tx_ready idle", tx_ready, 0);

        // Write with 50-cycle stall before data byte 2
        wdata = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        do_txn(1'b1, 15'h1234, 8'd4, 2, 1'b0);
        exp_b = '{8'h34, 8'h92, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
        chk_frame("stall", 6);
        chk("stall done pulses", dones, 1);

        // Read 0x7ffe, len 0
        do_txn(1'b0, 15'h7ffe, 8'd0, -1, 1'b0);
        exp_b = '{8'hfe, 8'h7f, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("rd7ffe len0", 2);
        chk("rd7ffe sck rises", rises, 16);
        chk("rd7ffe rx_valid pulses", rx_pulses, 0);
        chk("rd7ffe done pulses", dones, 1);

        // Write 0x7ffe: write flag set on top of 0x7f
        wdata = '{8'ha5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_txn(1'b1, 15'h7ffe, 8'd1, -1, 1'b0);
        exp_b = '{8'hfe, 8'hff, 8'ha5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("wr7ffe", 3);

        // Reset during frame byte 3 of a write
        clear_mon(1'b1, 15'h0abc);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        start = 1'b1; write = 1'b1; addr = 15'h0abc; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (k = 0; k < 4000; k++) begin
            if (rises >= 28) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reset-mid reached byte3", got, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset-mid _select", sel_n, 1);
        chk("reset-mid sck", sck, 0);
        chk("reset-mid busy", busy, 0);
        chk("reset-mid done", done, 0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("reset-mid no done", dones, 0);
        chk("reset-mid no rx_valid", rx_pulses, 0);
        chk("reset-mid stays idle", busy, 0);
        wdata = '{8'h0a, 8'h0b, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_txn(1'b1, 15'h0abc, 8'd2, -1, 1'b0);
        exp_b = '{8'hbc, 8'h8a, 8'h0a, 8'h0b, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("after reset", 4);

        // Starts while busy and on the done cycle are ignored
        do_txn(1'b0, 15'h0102, 8'd2, -1, 1'b1);
        exp_b  = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_rx = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("dblstart", 4);
        chk_rx("dblstart", 2);
        chk("dblstart sck rises", rises, 32);
        chk("dblstart done pulses", dones, 1);

        // Half-period timing at CLK_DIV=2 and 7 (len 0 frame = 36 half-periods)
        sel2 = 0; hi2 = 0; r2 = 0; sel7 = 0; hi7 = 0; r7 = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        got = 1'b0;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!a_busy2 && !a_busy7) begin
                got = 1'b1;
                break;
            end
        end
        chk("div frames finished", got, 1);
        chk("div2 select-low cycles", sel2, 72);
        chk("div2 sck-high cycles", hi2, 32);
        chk("div2 sck rises", r2, 16);
        chk("div7 select-low cycles", sel7, 252);
        chk("div7 sck-high cycles", hi7, 112);
        chk("div7 sck rises", r7, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
